// File: rtl/mux_sel_scanner_if.sv
// Stream and mux-select bundle between mux_sel_scanner, its starter, the 32:1 mux and the symbol consumer.
interface mux_sel_scanner_if #(
  parameter int NUM_CH = 32,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2
);
  logic              start;
  logic [NUM_CH-1:0] ch_mask;
  logic [SEL_W-1:0]  ctrl_sel;
  logic [DATA_W-1:0] mux_data;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_ch;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, ch_mask, mux_data, out_ready,
    output ctrl_sel, out_valid, out_ch, out_data, busy, done
  );

  modport slave (
    output start, ch_mask, mux_data, out_ready,
    input  ctrl_sel, out_valid, out_ch, out_data, busy, done
  );
endinterface

// File: rtl/mux_sel_scanner.sv
// Walks ctrl_sel over the enabled channels of a latched mask and streams each settled mux symbol.
// Optional SCAN_AUTO_RESTART_EN: a start seen in DONE immediately begins the next pass.
module mux_sel_scanner #(
  parameter int NUM_CH = 32,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  mux_sel_scanner_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_OUT, S_DONE} state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_mask;
  logic [SEL_W-1:0]  r_ctrl_sel;
  logic [SEL_W-1:0]  r_out_ch;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;

  logic [SEL_W:0]    w_first;
  logic [SEL_W:0]    w_next;

  // Lowest set bit of m at or above lo; MSB of the result flags that one exists.
  function automatic logic [SEL_W:0] find_from(input logic [NUM_CH-1:0] m, input int lo);
    find_from = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) find_from = {1'b1, SEL_W'(i)};
    end
  endfunction

  assign w_first = find_from(bus.ch_mask, 0);
  assign w_next  = find_from(r_mask, int'(r_out_ch) + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_ctrl_sel  <= '0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mask <= bus.ch_mask;
            if (w_first[SEL_W]) begin
              r_ctrl_sel <= w_first[SEL_W-1:0];
              r_busy     <= 1'b1;
              r_state    <= S_SETTLE;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        // The mux gets one full cycle on the new select before its output is captured.
        S_SETTLE: begin
          r_out_data  <= bus.mux_data;
          r_out_ch    <= r_ctrl_sel;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_next[SEL_W]) begin
              r_ctrl_sel <= w_next[SEL_W-1:0];
              r_state    <= S_SETTLE;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
`ifdef SCAN_AUTO_RESTART_EN
          if (bus.start) begin
            r_mask <= bus.ch_mask;
            if (w_first[SEL_W]) begin
              r_ctrl_sel <= w_first[SEL_W-1:0];
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_state    <= S_SETTLE;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
`else
          r_done  <= 1'b0;
          r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctrl_sel  = r_ctrl_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner with a mux model of data = ctrl_sel % 4.
module tb_mux_sel_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  mux_sel_scanner_if #(.NUM_CH(32), .SEL_W(5), .DATA_W(2)) bus ();

  mux_sel_scanner #(.NUM_CH(32), .SEL_W(5), .DATA_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mux_data = bus.ctrl_sel[1:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // During the sparse-mask scan only channels 0, 2 and 31 may ever be selected.
  always @(negedge clk) begin
    if (mon_en)
      chk("t2_sel_allowed", 32'((bus.ctrl_sel == 5'd0) || (bus.ctrl_sel == 5'd2) ||
                                (bus.ctrl_sel == 5'd31)), 32'd1);
  end

  task automatic run_scan(input string tag, input logic [31:0] m);
    bus.ch_mask = m;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_settle_valid"}, 32'(bus.out_valid), 32'd0);
    for (int ch = 0; ch < 32; ch++) begin
      if (m[ch]) begin
        tick();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_ch"}, 32'(bus.out_ch), ch);
        chk({tag, "_data"}, 32'(bus.out_data), ch % 4);
        chk({tag, "_sel"}, 32'(bus.ctrl_sel), ch);
        chk({tag, "_done_mid"}, 32'(bus.done), 32'd0);
        tick();
        chk({tag, "_valid_low"}, 32'(bus.out_valid), 32'd0);
      end
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    tick();
    chk({tag, "_done_clear"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start     = 1'b0;
    bus.ch_mask   = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sel", 32'(bus.ctrl_sel), 32'd0);
    chk("rst_ch", 32'(bus.out_ch), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: every channel enabled
    run_scan("t1", 32'hFFFF_FFFF);

    // Test 2: sparse mask, with the select monitor active
    mon_en = 1'b1;
    run_scan("t2", 32'h8000_0005);
    mon_en = 1'b0;

    // Test 3: empty mask finishes immediately without busy
    bus.ch_mask = 32'h0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    chk("t3_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_sel_hold", 32'(bus.ctrl_sel), 32'd31);
    tick();
    chk("t3_done_clear", 32'(bus.done), 32'd0);
    chk("t3_busy_after", 32'(bus.busy), 32'd0);
    chk("t3_valid_after", 32'(bus.out_valid), 32'd0);

    // Test 4: back-pressure on the ch1 beat
    bus.ch_mask   = 32'h0000_0006;
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t4_settle_sel", 32'(bus.ctrl_sel), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_ch", 32'(bus.out_ch), 32'd1);
      chk("t4_hold_data", 32'(bus.out_data), 32'd1);
      chk("t4_hold_sel", 32'(bus.ctrl_sel), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_rise1_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_rise1_sel", 32'(bus.ctrl_sel), 32'd2);
    tick();
    chk("t4_ch2_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_ch2_ch", 32'(bus.out_ch), 32'd2);
    chk("t4_ch2_data", 32'(bus.out_data), 32'd2);
    tick();
    chk("t4_done", 32'(bus.done), 32'd1);
    tick();
    chk("t4_done_clear", 32'(bus.done), 32'd0);

    // Test 5: ignored mid-scan start, then an abort by reset
    bus.ch_mask = 32'hFFFF_FFFF;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("t5_b0_ch", 32'(bus.out_ch), 32'd0);
    tick();
    tick();
    chk("t5_b1_ch", 32'(bus.out_ch), 32'd1);
    bus.start   = 1'b1;
    bus.ch_mask = 32'h0;
    tick();
    bus.start = 1'b0;
    chk("t5_ign_busy", 32'(bus.busy), 32'd1);
    chk("t5_ign_sel", 32'(bus.ctrl_sel), 32'd2);
    tick();
    chk("t5_b2_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_b2_ch", 32'(bus.out_ch), 32'd2);
    tick();
    chk("t5_pre_rst_sel", 32'(bus.ctrl_sel), 32'd3);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_done", 32'(bus.done), 32'd0);
    chk("t5_rst_sel", 32'(bus.ctrl_sel), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_no_done", 32'(bus.done), 32'd0);
    bus.ch_mask = 32'hFFFF_FFFF;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t5_restart_sel", 32'(bus.ctrl_sel), 32'd0);
    tick();
    chk("t5_restart_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_restart_ch", 32'(bus.out_ch), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Test 6: start held high through the end of a pass
    bus.ch_mask = 32'h0000_0003;
    bus.start   = 1'b1;
    tick();
    tick();
    chk("t6_b0_ch", 32'(bus.out_ch), 32'd0);
    tick();
    tick();
    chk("t6_b1_ch", 32'(bus.out_ch), 32'd1);
    tick();
    chk("t6_done", 32'(bus.done), 32'd1);
`ifdef SCAN_AUTO_RESTART_EN
    tick();
    chk("t6_auto_busy", 32'(bus.busy), 32'd1);
    chk("t6_auto_done_clear", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    tick();
    chk("t6_auto_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_auto_ch", 32'(bus.out_ch), 32'd0);
`else
    tick();
    chk("t6_idle_busy", 32'(bus.busy), 32'd0);
    chk("t6_idle_done_clear", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_idle_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_idle_busy_hold", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("t6_repulse_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_repulse_ch", 32'(bus.out_ch), 32'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
